// File: rtl/instruction_fetch.sv
// Instruction fetch stage: registers one word of an external combinational
// instruction memory per clock, indexed by a word-index program counter.
// Ports: clk, rst_n (async active-low), pc (word index), instr_mem (array),
//        instr / instr_pc / instr_valid / addr_err (registered to decode).
module instruction_fetch #(
   parameter int               DEPTH       = 32,
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_INSTR = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      pc,
   input  logic [WIDTH-1:0] instr_mem [0:DEPTH-1],
   output logic [WIDTH-1:0] instr,
   output logic [31:0]      instr_pc,
   output logic             instr_valid,
   output logic             addr_err
);

   localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] DEPTH_W = 32'(DEPTH);

   logic             in_range;
   logic [AW-1:0]    idx;
   logic [WIDTH-1:0] fetch_word;

   // Full 32-bit compare: upper pc bits must never alias into the array.
   assign in_range = (pc < DEPTH_W);
   assign idx      = pc[AW-1:0];

   always_comb begin
      fetch_word = RESET_INSTR;
      if (in_range)
         fetch_word = instr_mem[idx];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr       <= RESET_INSTR;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
         addr_err    <= 1'b0;
      end else begin
         instr       <= fetch_word;
         instr_pc    <= pc;
         instr_valid <= in_range;
         addr_err    <= ~in_range;
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a driver issues fetches and pushes
// expected results; a monitor pops and compares after each rising edge.
module tb_instruction_fetch;

   localparam int DEPTH = 32;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        valid;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] pc = 32'd3;
   logic [31:0] mem [0:DEPTH-1];
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        addr_err;

   int vectors = 0;
   int errors  = 0;
   bit done    = 1'b0;
   exp_t q[$];

   instruction_fetch #(
      .DEPTH(DEPTH),
      .WIDTH(32),
      .RESET_INSTR(32'h0000_0000)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .pc(pc),
      .instr_mem(mem),
      .instr(instr),
      .instr_pc(instr_pc),
      .instr_valid(instr_valid),
      .addr_err(addr_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: what a fetch of address a returns right now.
   function automatic exp_t model(input logic [31:0] a);
      exp_t e;
      e.pc = a;
      if (a < DEPTH) begin
         e.instr = mem[a];
         e.valid = 1'b1;
         e.err   = 1'b0;
      end else begin
         e.instr = 32'h0;
         e.valid = 1'b0;
         e.err   = 1'b1;
      end
      return e;
   endfunction

   task automatic chk_reset(input string tag);
      chk({tag, "_instr"}, instr, 32'h0);
      chk({tag, "_pc"}, instr_pc, 32'h0);
      chk({tag, "_valid"}, {31'b0, instr_valid}, 32'h0);
      chk({tag, "_err"}, {31'b0, addr_err}, 32'h0);
   endtask

   // Inputs change at the falling edge and are held through the next rise.
   task automatic issue(input logic [31:0] a);
      @(negedge clk);
      pc = a;
      q.push_back(model(a));
   endtask

   // Monitor
   always begin
      @(posedge clk);
      #1;
      if (rst_n && q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("instr", instr, e.instr);
         chk("instr_pc", instr_pc, e.pc);
         chk("valid", {31'b0, instr_valid}, {31'b0, e.valid});
         chk("addr_err", {31'b0, addr_err}, {31'b0, e.err});
      end
   end

   initial begin
      logic [31:0] a;
      int wait_cyc;
      for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000_0000 + i;
      mem[0]  = 32'h1234_5678;
      mem[1]  = 32'h9ABC_DEF0;
      mem[2]  = 32'h0F0F_0F0F;
      mem[3]  = 32'hF0F0_F0F0;
      mem[4]  = 32'hAAAA_AAAA;
      mem[5]  = 32'h5555_5555;
      mem[31] = 32'hCAFE_F00D;

      // Reset held with clock running
      #1 chk_reset("rst_t0");
      repeat (3) @(posedge clk);
      #2 chk_reset("rst_hold");

      // Release at falling edge, first fetch pc 0
      @(negedge clk);
      rst_n = 1'b1;
      pc = 32'd0;
      q.push_back(model(32'd0));

      // Latency: pc changes mid-cycle, output must not move
      @(negedge clk);
      pc = 32'd1;
      q.push_back(model(32'd1));
      #1 chk("latency_hold", instr, 32'h1234_5678);

      for (int i = 2; i < 6; i++) issue(32'(i));

      issue(32'd32);
      issue(32'hFFFF_FFFF);
      issue(32'd2);
      issue(32'd31);
      issue(32'h0000_0100);

      // Repeated pc re-reads memory rewritten between edges
      issue(32'd4);
      @(negedge clk);
      mem[4] = 32'hDEAD_BEEF;
      q.push_back(model(32'd4));

      // Async reset mid-cycle
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 chk_reset("rst_async");
      pc = 32'd7;
      repeat (2) @(posedge clk);
      #1 chk_reset("rst_held2");
      @(negedge clk);
      rst_n = 1'b1;
      q.push_back(model(32'd7));

      // Random traffic
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if ($urandom_range(0, 3) == 0)
            mem[$urandom_range(0, DEPTH-1)] = $urandom;
         case ($urandom_range(0, 9))
            0:       a = $urandom;
            1:       a = 32'(DEPTH) + $urandom_range(0, 3);
            2:       a = 32'(DEPTH - 1);
            default: a = $urandom_range(0, DEPTH-1);
         endcase
         pc = a;
         q.push_back(model(a));
      end

      wait_cyc = 0;
      while (q.size() > 0 && wait_cyc < 20) begin
         @(posedge clk);
         wait_cyc++;
      end
      #2;
      if (q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d left, expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
